// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides, status flags and an optional
// iterative shift-add multiplier (opcode 1000), enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_opcodes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal_op,
    output logic             busy
);

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, BUSY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

    state_t state, next_state;

    logic             load_single;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_ill;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;

    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

`ifdef ALU_SEQ_MUL_EN
    logic             start_mul;
    logic             mul_step;
    logic             mul_finish;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [SHW:0]     mul_cnt;
    logic [WIDTH:0]   mul_sum;

    // Multiplier bits are consumed LSB first; partial sum shifts right into mul_lo.
    assign mul_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : {(WIDTH+1){1'b0}});
`endif

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        case (alu_opcodes)
            4'b0000: alu_res = a & b;
            4'b0001: alu_res = a | b;
            4'b0010: begin
                alu_res   = add_full[WIDTH-1:0];
                alu_carry = add_full[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0011: alu_res = a ^ b;
            4'b0100: alu_res = a << b[SHW-1:0];
            4'b0101: alu_res = a >> b[SHW-1:0];
            4'b0110: begin
                alu_res   = sub_full[WIDTH-1:0];
                alu_carry = sub_full[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // In DONE the consumer's ready frees the slot, so a new op can be accepted the same cycle.
    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        load_single = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        start_mul   = 1'b0;
        mul_step    = 1'b0;
        mul_finish  = 1'b0;
`endif
        case (state)
            IDLE: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: begin
                busy = ~mul_cnt[SHW];
                if (mul_cnt[SHW]) begin
                    mul_finish = 1'b1;
                    next_state = DONE;
                end else begin
                    mul_step = 1'b1;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
        if (in_valid && in_ready) begin
`ifdef ALU_SEQ_MUL_EN
            if (alu_opcodes == 4'b1000) begin
                start_mul  = 1'b1;
                next_state = BUSY;
            end else begin
                load_single = 1'b1;
                next_state  = DONE;
            end
`else
            load_single = 1'b1;
            next_state  = DONE;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= '0;
            zero       <= 1'b0;
            carry      <= 1'b0;
            overflow   <= 1'b0;
            illegal_op <= 1'b0;
        end else if (load_single) begin
            result     <= alu_res;
            zero       <= (alu_res == '0);
            carry      <= alu_carry;
            overflow   <= alu_ovf;
            illegal_op <= alu_ill;
`ifdef ALU_SEQ_MUL_EN
        end else if (mul_finish) begin
            result     <= mul_lo;
            zero       <= (mul_lo == '0);
            carry      <= |mul_hi;
            overflow   <= 1'b0;
            illegal_op <= 1'b0;
`endif
        end
    end

`ifdef ALU_SEQ_MUL_EN
    // After WIDTH steps {mul_hi, mul_lo} holds the full 2*WIDTH product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a   <= '0;
            mul_hi  <= '0;
            mul_lo  <= '0;
            mul_cnt <= '0;
        end else if (start_mul) begin
            mul_a   <= a;
            mul_hi  <= '0;
            mul_lo  <= b;
            mul_cnt <= '0;
        end else if (mul_step) begin
            mul_hi  <= mul_sum[WIDTH:1];
            mul_lo  <= {mul_sum[0], mul_lo[WIDTH-1:1]};
            mul_cnt <= mul_cnt + {{SHW{1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational alu. It adds a valid/ready handshake on both sides, status flags, extra operations and an optional iterative multiplier.
- Sits in the execute stage between alu_control (which drives alu_opcodes) and the writeback logic.
- Width is generic, so the same block serves the 16-bit core and wider variants.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and opcode valid
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; shift amount is b[SHW-1:0]
- alu_opcodes  input  4  operation select
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- carry  output  1  ADD carry-out / SUB no-borrow / MUL high half nonzero
- overflow  output  1  signed overflow (ADD/SUB only, else 0)
- illegal_op  output  1  opcode not supported
- busy  output  1  multi-cycle operation in progress

Behaviour:
- Reset (rst_n low, async, any state): state=IDLE; result=0, zero=0, carry=0, overflow=0, illegal_op=0, out_valid=0, busy=0. Any in-flight operation is discarded.
- Opcodes (alu_opcodes):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed, result 1/0), 1000 MUL (optional feature).
  - All other codes: result=0, illegal_op=1, carry=overflow=0; completes with single-cycle latency.
- States:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready. MUL goes to BUSY; every other opcode computes and goes to DONE.
  - BUSY: one shift-add step per cycle, WIDTH steps, busy=1, in_ready=0. Goes to DONE after the last step.
  - DONE: out_valid=1; outputs held stable while out_ready=0.
    - out_ready=1 and in_valid=0: back to IDLE.
    - out_ready=1 and in_valid=1: in_ready=1, so the new operation is accepted in the same cycle (back-to-back, one result per cycle for single-cycle ops).
- Latency:
  - Single-cycle op accepted at edge N: out_valid at edge N+1.
  - MUL accepted at edge N: out_valid at edge N+WIDTH+1.
- Arithmetic:
  - ADD/SUB are WIDTH-bit wrap-around. carry = bit WIDTH of the (WIDTH+1)-bit sum; for SUB this is a + ~b + 1.
  - overflow = operand signs equal (ADD) or differ (SUB), and result sign differs from a.
  - Shifts are logical; shift amount 0 passes a unchanged.
  - MUL is unsigned. result = low WIDTH bits of the product; carry = |high WIDTH bits.
- zero is computed from the registered result for every opcode, including illegal (zero=1 there).
- Inputs are sampled only on the accepting edge. Changes to a/b/opcode during BUSY/DONE have no effect.
- in_valid low: no state change in IDLE.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: opcode 1000 is the iterative multiplier described above; BUSY state and busy output are active.
- Undefined:
  - 1000 is treated as illegal (single-cycle, illegal_op=1).
  - BUSY state is not generated and busy is tied to 0.
  - Multiplier datapath is removed.

Test Plan:
- Reset mid-MUL: a=16'h0003, b=16'h0005, MUL accepted, rst_n pulsed low 4 cycles later -> all outputs 0 immediately; state IDLE, in_ready=1 after release.
- ADD a=16'h7FFF, b=16'h0001 -> next cycle result=16'h8000, overflow=1, carry=0, zero=0. SUB a=16'h0001, b=16'h0002 -> result=16'hFFFF, carry=0. AND a=16'h00F0, b=16'h0F00 -> result=0, zero=1.
- Back-to-back, out_ready held 1: ADD 1+2, SUB 1-2, AND 1&2, OR 1|2 on consecutive cycles -> results 3, 16'hFFFF, 0, 3 on consecutive cycles, no bubbles.
- Backpressure: ADD 5+6 with out_ready=0 for 5 cycles -> out_valid=1 and result=11 held stable, in_ready=0; result retires on the cycle out_ready rises.
- MUL (ALU_SEQ_MUL_EN): a=16'h0100, b=16'h0101 -> out_valid exactly 17 cycles after accept, result=16'h0100, carry=1; busy=1 for 16 cycles.
- Illegal opcode 4'b1111 (and 1000 with macro undefined) -> result=0, illegal_op=1, zero=1 after 1 cycle; SLL a=16'h0001, b=16'h000F -> result=16'h8000; SLT a=16'hFFFF, b=16'h0001 -> result=1.
